// File: rtl/video_sync_sink_pkg.sv
// ---------------------------------------------------------------------------
// video_sync_sink_pkg
// Shared VGA definitions for the video sink stage:
//   vga_fc_t      - per-pixel frame control (sof = first pixel of frame,
//                   eol = last pixel of line)
//   VGA_*         - 640x480@60 timing constants used as parameter defaults
//   state_t       - sink sequencer states
//   vga_total()   - sums the four segments of one timing axis
// ---------------------------------------------------------------------------
package video_sync_sink_pkg;

  typedef struct packed {
    logic sof;
    logic eol;
  } vga_fc_t;

  localparam int FC_W = $bits(vga_fc_t);

  // 640x480 timing set
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  typedef enum logic [1:0] {
    ST_SEEK = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  function automatic int vga_total(input int disp, input int fp,
                                   input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_sync_sink_fifo.sv
// ---------------------------------------------------------------------------
// video_sync_fifo
// Synchronous first-word-fall-through FIFO. o_dout always shows the head
// entry while o_empty is low. A push while full is accepted only when a pop
// happens in the same cycle.
//   clk, rst  - clock, async active-high reset
//   i_push    - write i_din
//   i_din     - write data [WIDTH]
//   i_pop     - drop the head entry
//   o_dout    - head entry [WIDTH]
//   o_full    - no free entries
//   o_empty   - no valid entries
// ---------------------------------------------------------------------------
module video_sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // one extra pointer bit separates full from empty
  logic [AW:0]      r_wp, r_rp;
  logic             w_do_push, w_do_pop;

  assign o_empty   = (r_wp == r_rp);
  assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/video_sync_sink.sv
// ---------------------------------------------------------------------------
// video_sync_sink
// Last stage of the video chain. Buffers the ready/valid pixel stream in a
// small FIFO, generates VGA timing from free-running counters and pops one
// pixel per display-area clock. Loses lock on underflow or on a sof that
// arrives away from (0,0) and re-locks at the next frame boundary.
//
// Ports:
//   clk, rst        pixel clock, async active-high reset
//   src_vld/src_rdy upstream handshake (rdy = FIFO not full)
//   src_fc, src_rgb frame control and pixel data
//   vga_hsync/vsync active-low syncs, registered
//   vga_rgb         pixel to DAC, 0 outside display / when not showing
//   underflow       sticky, set when the display area finds the FIFO empty
//   locked          registered "sequencer is in RUN"
//   underflow_cnt   saturating underflow event count
//                   (only with VIDEO_SYNC_SINK_UFCNT_EN defined)
// ---------------------------------------------------------------------------
module video_sync_sink
  import video_sync_sink_pkg::*;
#(
  parameter int RGB_SIZE   = 12,
  parameter int H_DISPLAY  = VGA_H_DISPLAY,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_DISPLAY  = VGA_V_DISPLAY,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                src_vld,
  output logic                src_rdy,
  input  vga_fc_t             src_fc,
  input  logic [RGB_SIZE-1:0] src_rgb,
  output logic                vga_hsync,
  output logic                vga_vsync,
  output logic [RGB_SIZE-1:0] vga_rgb,
  output logic                underflow,
`ifdef VIDEO_SYNC_SINK_UFCNT_EN
  output logic [15:0]         underflow_cnt,
`endif
  output logic                locked
);

  localparam int H_TOTAL = vga_total(H_DISPLAY, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_DISPLAY, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int W       = FC_W + RGB_SIZE;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DISP = HW'(H_DISPLAY);
  localparam logic [HW-1:0] HS_BEG = HW'(H_DISPLAY + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DISP = VW'(V_DISPLAY);
  localparam logic [VW-1:0] VS_BEG = VW'(V_DISPLAY + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_DISPLAY + V_FP + V_SYNC);

  // -------------------------------------------------------------------------
  // timing counters
  // -------------------------------------------------------------------------
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_disp, w_frame_end, w_origin, w_hs_act, w_vs_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  assign w_disp      = (r_h < H_DISP) && (r_v < V_DISP);
  assign w_frame_end = (r_h == H_LAST) && (r_v == V_LAST);
  assign w_origin    = (r_h == '0) && (r_v == '0);
  assign w_hs_act    = (r_h >= HS_BEG) && (r_h < HS_END);
  assign w_vs_act    = (r_v >= VS_BEG) && (r_v < VS_END);

  // -------------------------------------------------------------------------
  // pixel FIFO
  // -------------------------------------------------------------------------
  logic [W-1:0]          w_head;
  vga_fc_t               w_head_fc;
  logic [RGB_SIZE-1:0]   w_head_rgb;
  logic                  w_full, w_empty, w_pop;
  logic                  w_unused_eol;

  assign src_rdy = !w_full;

  video_sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (src_vld && !w_full),
    .i_din   ({src_fc, src_rgb}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_fc    = vga_fc_t'(w_head[W-1 -: FC_W]);
  assign w_head_rgb   = w_head[RGB_SIZE-1:0];
  // eol travels with the pixel but the sink never checks line length
  assign w_unused_eol = w_head_fc.eol;

  // -------------------------------------------------------------------------
  // sequencer
  // -------------------------------------------------------------------------
  state_t r_state, w_state_nx;
  logic   w_show, w_uf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_SEEK;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_show     = 1'b0;
    w_uf       = 1'b0;
    case (r_state)
      // flush until a start-of-frame sits at the head
      ST_SEEK: begin
        if (!w_empty) begin
          if (w_head_fc.sof) w_state_nx = ST_WAIT;
          else               w_pop      = 1'b1;
        end
      end
      // hold the sof entry; leave on the last clock so it pops at (0,0)
      ST_WAIT: begin
        if (w_frame_end) w_state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (w_disp) begin
          if (w_empty) begin
            w_uf       = 1'b1;
            w_state_nx = ST_SEEK;
          end else if (w_head_fc.sof && !w_origin) begin
            // early frame start: keep the entry and line it up with (0,0)
            w_state_nx = ST_WAIT;
          end else begin
            w_pop  = 1'b1;
            w_show = 1'b1;
          end
        end
      end
      default: w_state_nx = ST_SEEK;
    endcase
  end

  // -------------------------------------------------------------------------
  // registered pins: one clock behind the counters
  // -------------------------------------------------------------------------
  logic                r_hsync, r_vsync, r_underflow, r_locked;
  logic [RGB_SIZE-1:0] r_rgb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_rgb       <= '0;
      r_underflow <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_hsync  <= !w_hs_act;
      r_vsync  <= !w_vs_act;
      r_rgb    <= w_show ? w_head_rgb : '0;
      r_locked <= (r_state == ST_RUN);
      if (w_uf) r_underflow <= 1'b1;
    end
  end

  assign vga_hsync = r_hsync;
  assign vga_vsync = r_vsync;
  assign vga_rgb   = r_rgb;
  assign underflow = r_underflow;
  assign locked    = r_locked;

`ifdef VIDEO_SYNC_SINK_UFCNT_EN
  logic [15:0] r_uf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_uf_cnt <= '0;
    else if (w_uf && (r_uf_cnt != 16'hFFFF)) r_uf_cnt <= r_uf_cnt + 16'd1;
  end

  assign underflow_cnt = r_uf_cnt;
`endif

endmodule

// File: tb/tb_video_sync_sink.sv
// Directed bench for video_sync_sink with a 14x7 timing raster and a 4-deep
// FIFO. n counts clock edges since reset release; the outputs seen after
// edge n belong to raster position (n-1) mod 98.
module tb_video_sync_sink;
  import video_sync_sink_pkg::*;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;
  localparam int HD = 8;
  localparam int VD = 4;

  logic        clk, rst, src_vld, src_rdy;
  vga_fc_t     src_fc;
  logic [11:0] src_rgb, vga_rgb;
  logic        vga_hsync, vga_vsync, underflow, locked;
`ifdef VIDEO_SYNC_SINK_UFCNT_EN
  logic [15:0] underflow_cnt;
`endif

  int          n_cmp, n_bad, n;
  bit          src_en;
  logic [13:0] srcq [$];   // {sof, eol, rgb}

  video_sync_sink #(
    .RGB_SIZE(12), .H_DISPLAY(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_DISPLAY(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_vld   (src_vld),
    .src_rdy   (src_rdy),
    .src_fc    (src_fc),
    .src_rgb   (src_rgb),
    .vga_hsync (vga_hsync),
    .vga_vsync (vga_vsync),
    .vga_rgb   (vga_rgb),
    .underflow (underflow),
`ifdef VIDEO_SYNC_SINK_UFCNT_EN
    .underflow_cnt (underflow_cnt),
`endif
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one clock: present queue head, advance, retire on handshake
  task automatic cyc();
    bit hs;
    src_vld = src_en && (srcq.size() > 0);
    if (srcq.size() > 0) begin
      src_fc  = vga_fc_t'(srcq[0][13:12]);
      src_rgb = srcq[0][11:0];
    end else begin
      src_fc  = '0;
      src_rgb = '0;
    end
    hs = src_vld && src_rdy;
    @(posedge clk);
    if (hs) void'(srcq.pop_front());
    #1;
    n++;
  endtask

  task automatic do_reset();
    src_en  = 1'b0;
    src_vld = 1'b0;
    srcq.delete();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n   = 0;
  endtask

  // frame pixel i sits at (h=i%8, v=i/8) and carries tag*32 + i
  task automatic push_frame(input int tag, input int npix);
    for (int i = 0; i < npix; i++)
      srcq.push_back({(i == 0), ((i % 8) == 7), 12'(tag * 32 + i)});
  endtask

  task automatic test_reset();
    src_en = 1'b0; src_vld = 1'b0; srcq.delete();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (vga_hsync !== 1'b1) begin n_bad++; $display("FAIL rst_hsync got %b want 1", vga_hsync); end
    n_cmp++; if (vga_vsync !== 1'b1) begin n_bad++; $display("FAIL rst_vsync got %b want 1", vga_vsync); end
    n_cmp++; if (vga_rgb !== 12'h0) begin n_bad++; $display("FAIL rst_rgb got %h want 000", vga_rgb); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked got %b want 0", locked); end
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL rst_underflow got %b want 0", underflow); end
    n_cmp++; if (src_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_src_rdy got %b want 1", src_rdy); end
`ifdef VIDEO_SYNC_SINK_UFCNT_EN
    n_cmp++; if (underflow_cnt !== 16'h0) begin n_bad++; $display("FAIL rst_ufcnt got %h want 0000", underflow_cnt); end
`endif
    rst = 1'b0; n = 0;
    push_frame(0, 32); push_frame(1, 32);
    src_en = 1'b1;
    // stop right after pixel (6,1) of the first locked frame
    repeat (FT + 21) cyc();
    n_cmp++; if (vga_rgb !== 12'd14) begin n_bad++; $display("FAIL mid_rgb got %h want 00e", vga_rgb); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL mid_locked got %b want 1", locked); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (vga_rgb !== 12'h0) begin n_bad++; $display("FAIL async_rgb got %h want 000", vga_rgb); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL async_locked got %b want 0", locked); end
    n_cmp++; if (vga_hsync !== 1'b1) begin n_bad++; $display("FAIL async_hsync got %b want 1", vga_hsync); end
    n_cmp++; if (vga_vsync !== 1'b1) begin n_bad++; $display("FAIL async_vsync got %b want 1", vga_vsync); end
    src_en = 1'b0; src_vld = 1'b0; srcq.delete();
    @(negedge clk);
    rst = 1'b0; n = 0;
    // counters restart: hsync must drop exactly at h=10,11 of line 0
    repeat (HT) begin
      cyc();
      n_cmp++;
      if (vga_hsync !== !((n - 1) >= 10 && (n - 1) < 12)) begin
        n_bad++; $display("FAIL restart_hsync n=%0d got %b", n, vga_hsync);
      end
      n_cmp++; if (vga_vsync !== 1'b1) begin n_bad++; $display("FAIL restart_vsync n=%0d got %b want 1", n, vga_vsync); end
    end
  endtask

  task automatic test_timing();
    int p, h, v;
    do_reset();
    repeat (2 * FT) begin
      cyc();
      p = (n - 1) % FT; h = p % HT; v = p / HT;
      n_cmp++; if (vga_hsync !== !(h >= 10 && h < 12)) begin n_bad++; $display("FAIL tim_hsync n=%0d got %b", n, vga_hsync); end
      n_cmp++; if (vga_vsync !== !(v == 5)) begin n_bad++; $display("FAIL tim_vsync n=%0d got %b", n, vga_vsync); end
      n_cmp++; if (vga_rgb !== 12'h0) begin n_bad++; $display("FAIL tim_rgb n=%0d got %h want 000", n, vga_rgb); end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL tim_locked n=%0d got %b want 0", n, locked); end
    end
  endtask

  // locks on frame 1; displayed frame f shows source tag f-1
  task automatic test_stream(input bit garbage);
    int p, f, h, v;
    logic [11:0] er;
    do_reset();
    if (garbage) for (int i = 0; i < 3; i++) srcq.push_back({2'b00, 12'(12'hF00 + i)});
    for (int t = 0; t < 4; t++) push_frame(t, 32);
    src_en = 1'b1;
    repeat (3 * FT) begin
      cyc();
      p = (n - 1) % FT; f = (n - 1) / FT; h = p % HT; v = p / HT;
      er = (f >= 1 && h < HD && v < VD) ? 12'((f - 1) * 32 + v * 8 + h) : 12'h0;
      n_cmp++; if (vga_rgb !== er) begin n_bad++; $display("FAIL stream%0d_rgb n=%0d got %h want %h", garbage, n, vga_rgb, er); end
      n_cmp++; if (locked !== (f >= 1)) begin n_bad++; $display("FAIL stream%0d_locked n=%0d got %b", garbage, n, locked); end
      n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL stream%0d_uf n=%0d got %b want 0", garbage, n, underflow); end
    end
  endtask

  task automatic test_starve();
    int p, f, h, v;
    bit disp;
    logic [11:0] er;
    logic el, eu;
    do_reset();
    push_frame(0, 10);
    src_en = 1'b1;
    repeat (3 * FT) begin
      cyc();
      p = (n - 1) % FT; f = (n - 1) / FT; h = p % HT; v = p / HT;
      disp = (h < HD) && (v < VD);
      if (f == 0) begin
        er = 12'h0; el = 1'b0; eu = 1'b0;
      end else if (f == 1) begin
        // ten pixels shown, the eleventh (2,1) at p=16 starves
        er = (disp && p < 16) ? 12'(v * 8 + h) : 12'h0;
        el = (p <= 16); eu = (p >= 16);
      end else begin
        er = disp ? 12'(256 + v * 8 + h) : 12'h0;
        el = 1'b1; eu = 1'b1;
      end
      n_cmp++; if (vga_rgb !== er) begin n_bad++; $display("FAIL starve_rgb n=%0d got %h want %h", n, vga_rgb, er); end
      n_cmp++; if (locked !== el) begin n_bad++; $display("FAIL starve_locked n=%0d got %b want %b", n, locked, el); end
      n_cmp++; if (underflow !== eu) begin n_bad++; $display("FAIL starve_uf n=%0d got %b want %b", n, underflow, eu); end
      if (n == FT + 21) push_frame(8, 32);
    end
`ifdef VIDEO_SYNC_SINK_UFCNT_EN
    n_cmp++; if (underflow_cnt !== 16'd1) begin n_bad++; $display("FAIL starve_ufcnt got %0d want 1", underflow_cnt); end
`endif
  endtask

  task automatic test_resync();
    int p, f, h, v;
    bit disp;
    logic [11:0] er;
    logic el;
    do_reset();
    push_frame(0, 11);   // cut short: next entry (a sof) lands at (3,1)
    push_frame(8, 32);
    push_frame(9, 32);
    src_en = 1'b1;
    repeat (4 * FT) begin
      cyc();
      p = (n - 1) % FT; f = (n - 1) / FT; h = p % HT; v = p / HT;
      disp = (h < HD) && (v < VD);
      if (f == 0) begin
        er = 12'h0; el = 1'b0;
      end else if (f == 1) begin
        er = (disp && p < 17) ? 12'(v * 8 + h) : 12'h0;
        el = (p <= 17);
      end else begin
        er = disp ? 12'((f == 2 ? 256 : 288) + v * 8 + h) : 12'h0;
        el = 1'b1;
      end
      n_cmp++; if (vga_rgb !== er) begin n_bad++; $display("FAIL resync_rgb n=%0d got %h want %h", n, vga_rgb, er); end
      n_cmp++; if (locked !== el) begin n_bad++; $display("FAIL resync_locked n=%0d got %b want %b", n, locked, el); end
      n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL resync_uf n=%0d got %b want 0", n, underflow); end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n = 0;
    rst = 1'b0; src_en = 1'b0; src_vld = 1'b0; src_fc = '0; src_rgb = '0;
    #2;
    test_reset();
    test_timing();
    test_stream(1'b0);
    test_stream(1'b1);
    test_starve();
    test_resync();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
